// File: rtl/line_clear_engine_pkg.sv
// Shared types and defaults for the playfield line-clear engine.
package line_clear_engine_pkg;

  localparam int DEFAULT_BOARD_W = 10;
  localparam int DEFAULT_BOARD_H = 20;
  localparam int DEFAULT_CELL_W  = 3;

  typedef enum logic [DEFAULT_CELL_W-1:0] {
    EMPTY  = 3'd0,
    CYAN   = 3'd1,
    YELLOW = 3'd2,
    PURPLE = 3'd3,
    GREEN  = 3'd4,
    RED    = 3'd5,
    BLUE   = 3'd6,
    ORANGE = 3'd7
  } block_color;

  typedef block_color [DEFAULT_BOARD_W-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FILL,
    ST_DONE
  } lce_state_e;

endpackage

// File: rtl/line_clear_engine_row_classify.sv
// Combinational row classifier: reports whether a row is completely occupied or completely empty.
module line_clear_engine_row_classify
  import line_clear_engine_pkg::*;
#(
  parameter int BOARD_W = DEFAULT_BOARD_W,
  parameter int CELL_W  = DEFAULT_CELL_W
) (
  input  logic [BOARD_W*CELL_W-1:0] row,
  output logic                      is_full,
  output logic                      is_empty
);

  logic [BOARD_W-1:0] occupied;

  for (genvar gi = 0; gi < BOARD_W; gi++) begin : g_cell
    assign occupied[gi] = (row[gi*CELL_W +: CELL_W] != CELL_W'(EMPTY));
  end

  assign is_full  = &occupied;
  assign is_empty = ~|occupied;

endmodule

// File: rtl/line_clear_engine.sv
// Line-clear and gravity engine: scans the board bottom-up one row per cycle,
// drops full rows, compacts the rest downward and refills the vacated top rows.
module line_clear_engine
  import line_clear_engine_pkg::*;
#(
  parameter int BOARD_W       = DEFAULT_BOARD_W,
  parameter int BOARD_H       = DEFAULT_BOARD_H,
  parameter int CELL_W        = DEFAULT_CELL_W,
  parameter bit STOP_ON_EMPTY = 1'b1,
  parameter int ROW_AW        = $clog2(BOARD_H)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [ROW_AW-1:0]              rd_row,
  input  logic [BOARD_W*CELL_W-1:0]      rd_data,
  output logic                           wr_en,
  output logic [ROW_AW-1:0]              wr_row,
  output logic [BOARD_W*CELL_W-1:0]      wr_data,
  output logic [$clog2(BOARD_H+1)-1:0]   lines_cleared,
  output logic [BOARD_H-1:0]             cleared_mask
);

  localparam int ROW_BITS = BOARD_W * CELL_W;
  localparam int PTR_W    = ROW_AW + 1;
  localparam int CNT_W    = $clog2(BOARD_H + 1);
  localparam logic [ROW_BITS-1:0] EMPTY_ROW = {BOARD_W{CELL_W'(EMPTY)}};

  lce_state_e         state_reg;
  logic [PTR_W-1:0]   src_reg;
  logic [PTR_W-1:0]   dst_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   fill_left_reg;
  logic [BOARD_H-1:0] mask_reg;

  logic               row_is_full;
  logic               row_is_empty;
  logic               scan_active;
  logic               empty_stop;
  logic               scan_exit;
  logic               copy_row;
  logic [CNT_W-1:0]   cnt_next;
  logic [BOARD_H-1:0] mask_next;

  line_clear_engine_row_classify #(
    .BOARD_W(BOARD_W),
    .CELL_W (CELL_W)
  ) u_classify (
    .row     (rd_data),
    .is_full (row_is_full),
    .is_empty(row_is_empty)
  );

  assign scan_active = (state_reg == ST_SCAN);
  assign empty_stop  = STOP_ON_EMPTY && row_is_empty;
  assign scan_exit   = (src_reg == '0) || empty_stop;
  // A terminating empty row is left alone: it and everything above it is already empty.
  assign copy_row    = scan_active && !row_is_full && !empty_stop && (src_reg != dst_reg);
  assign cnt_next    = cnt_reg + CNT_W'(row_is_full);
  assign mask_next   = row_is_full ? (mask_reg | (BOARD_H'(1) << src_reg[ROW_AW-1:0])) : mask_reg;

  assign rd_row = scan_active ? src_reg[ROW_AW-1:0] : '0;

  always_comb begin
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    if (copy_row) begin
      wr_en   = 1'b1;
      wr_row  = dst_reg[ROW_AW-1:0];
      wr_data = rd_data;
    end else if (state_reg == ST_FILL) begin
      wr_en   = 1'b1;
      wr_row  = dst_reg[ROW_AW-1:0];
      wr_data = EMPTY_ROW;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= ST_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      cnt_reg       <= '0;
      fill_left_reg <= '0;
      mask_reg      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lines_cleared <= '0;
      cleared_mask  <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_SCAN;
            src_reg       <= PTR_W'(BOARD_H - 1);
            dst_reg       <= PTR_W'(BOARD_H - 1);
            cnt_reg       <= '0;
            mask_reg      <= '0;
            lines_cleared <= '0;
            cleared_mask  <= '0;
            busy          <= 1'b1;
          end
        end
        ST_SCAN: begin
          cnt_reg  <= cnt_next;
          mask_reg <= mask_next;
          src_reg  <= src_reg - PTR_W'(1);
          if (!row_is_full && !empty_stop) begin
            dst_reg <= dst_reg - PTR_W'(1);
          end
          if (scan_exit) begin
            if (cnt_next == '0) begin
              state_reg     <= ST_DONE;
              done          <= 1'b1;
              busy          <= 1'b0;
              lines_cleared <= cnt_next;
              cleared_mask  <= mask_next;
            end else begin
              state_reg     <= ST_FILL;
              fill_left_reg <= cnt_next;
            end
          end
        end
        ST_FILL: begin
          dst_reg       <= dst_reg - PTR_W'(1);
          fill_left_reg <= fill_left_reg - CNT_W'(1);
          if (fill_left_reg == CNT_W'(1)) begin
            state_reg     <= ST_DONE;
            done          <= 1'b1;
            busy          <= 1'b0;
            lines_cleared <= cnt_reg;
            cleared_mask  <= mask_reg;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: directed table, corner sequences and random boards vs a reference model.
module tb_line_clear_engine;

  localparam int W    = 10;
  localparam int H    = 20;
  localparam int CW   = 3;
  localparam int RB   = W * CW;
  localparam int AW   = 5;
  localparam int CNTW = 5;

  typedef logic [RB-1:0] img_t [H];

  typedef struct {
    logic [H-1:0] full_mask;
    int           height;
    int           exp_lines;
    logic [H-1:0] exp_mask;
    int           exp_done;
    int           exp_writes;
  } vec_t;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, wr_en;
  logic [AW-1:0]   rd_row, wr_row;
  logic [RB-1:0]   rd_data, wr_data;
  logic [CNTW-1:0] lines_cleared;
  logic [H-1:0]    cleared_mask;

  img_t board;
  img_t load_img;
  logic load_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  line_clear_engine #(
    .BOARD_W(W), .BOARD_H(H), .CELL_W(CW), .STOP_ON_EMPTY(1'b1), .ROW_AW(AW)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
    .rd_row(rd_row), .rd_data(rd_data), .wr_en(wr_en), .wr_row(wr_row),
    .wr_data(wr_data), .lines_cleared(lines_cleared), .cleared_mask(cleared_mask)
  );

  // Board register file as seen by the engine.
  assign rd_data = (int'(rd_row) < H) ? board[rd_row] : '0;

  always @(posedge Clk) begin
    if (load_en) begin
      for (int i = 0; i < H; i++) board[i] <= load_img[i];
    end else if (wr_en) begin
      board[wr_row] <= wr_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit row_full(input logic [RB-1:0] r);
    for (int c = 0; c < W; c++) if (r[c*CW +: CW] == '0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit row_empty(input logic [RB-1:0] r);
    return r == '0;
  endfunction

  // Reference: keep non-full rows in bottom-up order, stop at the first empty row, restack at the bottom.
  function automatic void ref_model(input img_t in, output img_t out, output int lines,
                                    output logic [H-1:0] mask, output int scans, output int copies);
    logic [RB-1:0] kept[$];
    lines = 0; mask = '0; scans = 0; copies = 0;
    for (int r = H - 1; r >= 0; r--) begin
      scans++;
      if (row_empty(in[r])) break;
      if (row_full(in[r])) begin
        lines++;
        mask[r] = 1'b1;
      end else begin
        if (H - 1 - kept.size() != r) copies++;
        kept.push_back(in[r]);
      end
    end
    for (int i = 0; i < H; i++) out[i] = '0;
    for (int k = 0; k < kept.size(); k++) out[H-1-k] = kept[k];
  endfunction

  function automatic void make_img(input logic [H-1:0] fm, input int height, output img_t img);
    for (int r = 0; r < H; r++) begin
      img[r] = '0;
      if (r >= H - height) begin
        for (int c = 0; c < W; c++) begin
          if (fm[r]) img[r][c*CW +: CW] = CW'(((r + c) % 7) + 1);
          else       img[r][c*CW +: CW] = CW'(((r * 3 + c) % 7) + 1);
        end
        if (!fm[r]) img[r][(r % W)*CW +: CW] = '0;
      end
    end
  endfunction

  function automatic void rand_img(output img_t img);
    int h;
    int z;
    h = $urandom_range(0, H);
    for (int r = 0; r < H; r++) begin
      img[r] = '0;
      if (r >= H - h) begin
        if ($urandom_range(0, 2) == 0) begin
          for (int c = 0; c < W; c++) img[r][c*CW +: CW] = CW'($urandom_range(1, 7));
        end else begin
          for (int c = 0; c < W; c++) img[r][c*CW +: CW] = CW'($urandom_range(0, 7));
          z = $urandom_range(0, W - 1);
          img[r][z*CW +: CW] = '0;
          img[r][((z + 1) % W)*CW +: CW] = CW'($urandom_range(1, 7));
        end
      end
    end
  endfunction

  task automatic load_board(input img_t img);
    @(negedge Clk);
    load_img = img;
    load_en = 1'b1;
    @(negedge Clk);
    load_en = 1'b0;
  endtask

  // Start at cycle 0; cycle k is the k-th cycle after the start edge.
  task automatic run_pass(input bit hold, output int dcyc, output int nwr, output int nd, output logic busy1);
    dcyc = -1; nwr = 0; nd = 0;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    busy1 = busy;
    for (int k = 1; k <= 150; k++) begin
      start = hold && (busy || done);
      if (wr_en) nwr++;
      if (done) begin
        nd++;
        if (dcyc < 0) dcyc = k;
      end
      if (dcyc >= 0 && k >= dcyc + 5) break;
      @(negedge Clk);
    end
    start = 1'b0;
  endtask

  task automatic chk_board(input string tag, input img_t exp);
    int bad = 0;
    for (int r = 0; r < H; r++) if (board[r] !== exp[r]) bad++;
    chk({tag, " board_rows_wrong"}, bad, 0);
  endtask

  task automatic do_pass(input string tag, input img_t img, input bit hold, input int exp_lines,
                         input logic [H-1:0] exp_mask, input int exp_done, input int exp_writes);
    img_t exp_img;
    int ml, ms, mc, dcyc, nwr, nd;
    logic [H-1:0] mm;
    logic busy1;
    ref_model(img, exp_img, ml, mm, ms, mc);
    load_board(img);
    run_pass(hold, dcyc, nwr, nd, busy1);
    $display("%s: lines=%0d mask=%05h done_cycle=%0d writes=%0d done_pulses=%0d",
             tag, lines_cleared, cleared_mask, dcyc, nwr, nd);
    chk({tag, " busy_after_start"}, busy1, 1);
    chk({tag, " done_cycle"}, dcyc, exp_done);
    chk({tag, " done_pulses"}, nd, 1);
    chk({tag, " writes"}, nwr, exp_writes);
    chk({tag, " lines_cleared"}, lines_cleared, exp_lines);
    chk({tag, " cleared_mask"}, cleared_mask, exp_mask);
    chk({tag, " busy_idle"}, busy, 0);
    chk_board(tag, exp_img);
  endtask

  vec_t vecs[6];

  initial begin
    img_t img, eimg;
    int ml, ms, mc, nd;
    logic [H-1:0] mm;

    vecs[0] = '{20'h00000,  0,  0, 20'h00000,  2,  0};
    vecs[1] = '{20'h80000,  2,  1, 20'h80000,  5,  2};
    vecs[2] = '{20'hB4000, 20,  4, 20'hB4000, 25, 20};
    vecs[3] = '{20'hFFFFF, 20, 20, 20'hFFFFF, 41, 20};
    vecs[4] = '{20'h08000,  5,  1, 20'h08000,  8,  1};
    vecs[5] = '{20'h00000, 20,  0, 20'h00000, 21,  0};

    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset rd_row", rd_row, 0);
    chk("reset wr_row", wr_row, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset lines_cleared", lines_cleared, 0);
    chk("reset cleared_mask", cleared_mask, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      make_img(vecs[v].full_mask, vecs[v].height, img);
      do_pass($sformatf("vec%0d", v), img, 1'b0, vecs[v].exp_lines, vecs[v].exp_mask,
              vecs[v].exp_done, vecs[v].exp_writes);
    end

    // start held high throughout busy and DONE: one pass only
    make_img(vecs[2].full_mask, vecs[2].height, img);
    do_pass("hold_start", img, 1'b1, 4, 20'hB4000, 25, 20);

    // reset asserted during SCAN cycle 5
    load_board(img);
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (4) @(negedge Clk);
    chk("midreset busy_before", busy, 1);
    chk("midreset wr_en_before", wr_en, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset wr_en", wr_en, 0);
    chk("midreset rd_row", rd_row, 0);
    chk("midreset wr_row", wr_row, 0);
    chk("midreset lines_cleared", lines_cleared, 0);
    chk("midreset cleared_mask", cleared_mask, 0);
    nd = 0;
    repeat (3) begin
      @(negedge Clk);
      if (done) nd++;
    end
    chk("midreset no_done", nd, 0);
    Reset_n = 1'b1;
    do_pass("after_reset", img, 1'b0, 4, 20'hB4000, 25, 20);

    for (int t = 0; t < 25; t++) begin
      rand_img(img);
      ref_model(img, eimg, ml, mm, ms, mc);
      do_pass($sformatf("rand%0d", t), img, 1'b0, ml, mm, 1 + ms + ml, mc + ml);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
Sequential, parametrised line-clear and gravity engine for the Tetris playfield. On a start pulse it scans the board one row per cycle, bottom to top, through a row-wide read/write port into the board register file. It removes every full row, compacts the remaining rows downward and refills the vacated top rows with EMPTY. It reports the clear count and a mask of the cleared rows for scoring and the flash animation.

Parameters:
BOARD_W, 10, columns per row
BOARD_H, 20, rows; row 0 is the top, row BOARD_H-1 is the bottom
CELL_W, 3, bits per cell (width of block_color); cell value 0 is EMPTY
STOP_ON_EMPTY, 1, when 1, the scan terminates at the first all-EMPTY row
ROW_AW, $clog2(BOARD_H), row address width (derived)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to run a pass; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  single-cycle pulse when the board is consistent
rd_row  out  ROW_AW  row address; combinational read of the board file
rd_data  in  BOARD_W*CELL_W  row contents; cell c at [c*CELL_W +: CELL_W]
wr_en  out  1  row write strobe, committed at the next Clk edge
wr_row  out  ROW_AW  row address to write
wr_data  out  BOARD_W*CELL_W  row data to write
lines_cleared  out  $clog2(BOARD_H+1)  rows removed by the last pass
cleared_mask  out  BOARD_H  bit r set = original row r was full

Behaviour:
- Reset (async, Reset_n low): state IDLE; busy, done, wr_en = 0; rd_row, wr_row, wr_data = 0; lines_cleared = 0; cleared_mask = 0.
- States: IDLE, SCAN, FILL, DONE.
- IDLE:
  - start=1 -> SCAN. Set src=dst=BOARD_H-1; clear cnt and mask. Output lines_cleared and mask are cleared at the same edge.
  - start while busy or in DONE is ignored.
- SCAN (one row per cycle):
  - rd_row = src. Full = every cell != EMPTY. Empty = every cell == EMPTY.
  - Full: set mask[src]; cnt+1; no write; dst unchanged.
  - Not full and src != dst: wr_en=1, wr_row=dst, wr_data=rd_data; dst-1.
  - Not full and src == dst: no write; dst-1.
  - Exit condition: after src==0 is processed, or (STOP_ON_EMPTY and the row is empty).
  - On exit: cnt==0 -> DONE; else FILL.
  - The empty row itself is never written; rows above it are already empty by game invariant.
- FILL:
  - Write EMPTY row to dst; dst-1; one row per cycle.
  - Exactly cnt cycles; these are the vacated rows dst down to dst-cnt+1.
  - Then -> DONE.
- DONE: done=1 for exactly one cycle; busy=0; lines_cleared=cnt and cleared_mask latched; -> IDLE.
- lines_cleared and cleared_mask hold until the next accepted start.
- Latency, start edge to done cycle (STOP_ON_EMPTY=0): BOARD_H + cnt + 1 cycles.
- Boundaries:
  - All rows full: cnt=BOARD_H; zero copies; FILL writes all BOARD_H rows.
  - Empty board with STOP_ON_EMPTY=1: exactly 1 SCAN cycle, no writes.
  - Empty board with STOP_ON_EMPTY=0: BOARD_H scan cycles, no writes.
- Read/write hazard: every write targets dst >= src. That row has already been read, so no forwarding is needed. The board file must not be modified by others while busy.
- Reset mid-pass: immediate return to IDLE; the board may be partially compacted (owner re-initialises). No done is issued.
- Arithmetic:
  - src and dst are ROW_AW+1 bits signed-safe; src underflow past 0 ends the scan.
  - cnt saturation is impossible, since width holds BOARD_H.

Decomposition:
- Shared package (types): block_color enum with EMPTY=0, BOARD_W/BOARD_H defaults, CELL_W, and a row_t packed type.
- Sub-module row_classify: purely combinational. Takes a row and produces is_full and is_empty. It is reused by spawn/top-out detection.
- The FSM and pointers stay in line_clear_engine.

Test Plan:
- Empty board, STOP_ON_EMPTY=1, start -> done 2 cycles after start; no wr_en; lines_cleared=0; mask=0.
- Bottom row 19 full, row 18 = pattern P, rows above empty -> row19=P, row18=EMPTY; lines_cleared=1; mask=20'h80000.
- Rows 19,17,16,14 full, others non-full distinct patterns (STOP_ON_EMPTY=0) -> rows compacted in order, rows 0-3 EMPTY; lines_cleared=4; done at cycle 25.
- All 20 rows full -> 20 FILL writes; board all EMPTY; lines_cleared=20; mask=all ones.
- start reasserted each cycle during busy -> exactly one pass; exactly one done pulse.
- Reset_n low on SCAN cycle 5 -> outputs return to reset values asynchronously; no done; next start runs a complete pass.
